imem_loader: RTL and testbench

Streaming program loader that fills the fetch-stage instruction memory through a write port, replacing hierarchical Imem preloading.
- Accepts a byte stream over a valid/ready handshake.
- Assembles bytes little-endian into 32-bit instructions and writes them to consecutive Imem words from index 0.
- Verifies a trailing 32-bit checksum.
- Holds the processor (core_hold) until a load completes cleanly.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streaming instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to Imem from index 0, verifies a trailing checksum.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state, state_next;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     loaded_q;
  logic [1:0]          byte_idx;
  logic [23:0]         asm_q;
  logic [31:0]         acc_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                err_q;
  logic                accept;
  logic                count_bad;
  logic                last_word;

  assign accept     = rx_valid & rx_ready;
  assign count_bad  = (word_count == '0) || (word_count > MAX_COUNT);
  assign last_word  = ((loaded_q + 1'b1) == count_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_next = count_bad ? DONE : LOAD;
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        imem_we    = 1'b1;
        state_next = last_word ? CHECK : LOAD;
      end
      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == 2'd3) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The write address/data registers are loaded on the 4th byte so they are
  // valid throughout WRITE and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      loaded_q <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      acc_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (count_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q    <= 1'b0;
              count_q  <= word_count;
              loaded_q <= '0;
              acc_q    <= '0;
              byte_idx <= '0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wdata_q <= {rx_data, asm_q};
              addr_q  <= loaded_q[ADDR_W-1:0];
            end else begin
              asm_q[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end
        WRITE: begin
          acc_q    <= acc_q + wdata_q;
          loaded_q <= loaded_q + 1'b1;
        end
        CHECK: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) err_q <= ({rx_data, asm_q} != acc_q);
            else                  asm_q[{byte_idx, 3'b000} +: 8] <= rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign done         = (state == DONE);
  assign err          = err_q;
  assign core_hold    = (state == DONE) ? err_q : 1'b1;
  assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clean/bad-checksum loads, backpressure,
// bad counts, reset mid-load and a full-depth load.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .word_count   (word_count),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [5] = '{32'h40118133, 32'h00517633, 32'h002366B3,
                            32'h00217733, 32'h00F100A3};
  logic [31:0] wr_data [$];
  int          wr_addr [$];
  int          ready_in_write = 0;
  bit          bp_mode = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      if (rx_ready) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic took;
    int   n;
    if (bp_mode) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 100) begin
      @(negedge clk);
      took = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!took) check("rx_timeout", {31'b0, took}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    word_count = n[ADDR_W:0];
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done();
    logic d;
    int   k;
    d = 1'b0;
    k = 0;
    while (!d && k < 50) begin
      @(negedge clk);
      d = done;
      k++;
    end
    check("done_wait", {31'b0, d}, 32'd1);
    @(posedge clk); #1;
  endtask

  // kind 0: program words from prog[], kind 1: word i carries value i
  task automatic run_load(input int n, input int kind, input logic [31:0] chk);
    wr_addr.delete();
    wr_data.delete();
    do_start(n);
    for (int i = 0; i < n; i++) send_word(kind == 0 ? prog[i] : 32'(i));
    send_word(chk);
    rx_valid = 1'b0;
    wait_done();
  endtask

  task automatic check_writes(input string tag, input int n, input int kind);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
      check({tag, "_data"}, wr_data[i], kind == 0 ? prog[i] : 32'(i));
    end
  endtask

  task automatic check_end(input string tag, input logic e, input int n);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_err"}, {31'b0, err}, {31'b0, e});
    check({tag, "_hold"}, {31'b0, core_hold}, {31'b0, e});
    check({tag, "_wl"}, 32'(words_loaded), 32'(n));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {31'b0, core_hold}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // clean load, rx_valid held high through WRITE cycles
    run_load(5, 0, 32'h4198D5EF);
    check_writes("clean", 5, 0);
    check_end("clean", 1'b0, 5);
    check("clean_rdy_wr", 32'(ready_in_write), 32'd0);

    // restart from DONE with bad checksum; first LOAD cycle re-holds the core
    wr_addr.delete();
    wr_data.delete();
    do_start(5);
    check("restart_done", {31'b0, done}, 32'd0);
    check("restart_err", {31'b0, err}, 32'd0);
    check("restart_hold", {31'b0, core_hold}, 32'd1);
    for (int i = 0; i < 5; i++) send_word(prog[i]);
    send_word(32'h4198D5EE);
    rx_valid = 1'b0;
    wait_done();
    check_writes("badsum", 5, 0);
    check_end("badsum", 1'b1, 5);

    // backpressure: rx_valid alternates 0/1
    bp_mode = 1'b1;
    run_load(5, 0, 32'h4198D5EF);
    bp_mode = 1'b0;
    check_writes("bp", 5, 0);
    check_end("bp", 1'b0, 5);
    check("bp_rdy_wr", 32'(ready_in_write), 32'd0);

    // bad counts
    wr_addr.delete();
    wr_data.delete();
    do_start(0);
    check("cnt0_done", {31'b0, done}, 32'd1);
    check("cnt0_err", {31'b0, err}, 32'd1);
    check("cnt0_hold", {31'b0, core_hold}, 32'd1);
    rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    do_start(1025);
    check("cnt1025_done", {31'b0, done}, 32'd1);
    check("cnt1025_err", {31'b0, err}, 32'd1);
    check("cnt1025_hold", {31'b0, core_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("badcnt_nwr", 32'(wr_addr.size()), 32'd0);
    wr_addr.delete();
    wr_data.delete();
    do_start(1);
    send_word(32'h40118133);
    send_word(32'h40118133);
    rx_valid = 1'b0;
    wait_done();
    check_writes("cnt1", 1, 0);
    check_end("cnt1", 1'b0, 1);

    // reset after 2 bytes of word 2
    wr_addr.delete();
    wr_data.delete();
    do_start(5);
    send_word(prog[0]);
    send_word(prog[1]);
    send_byte(prog[2][7:0]);
    send_byte(prog[2][15:8]);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_hold", {31'b0, core_hold}, 32'd1);
    check("mid_wl", 32'(words_loaded), 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    check("mid_ready", {31'b0, rx_ready}, 32'd0);
    check("mid_nwr", 32'(wr_addr.size()), 32'd2);
    run_load(5, 0, 32'h4198D5EF);
    check_writes("fresh", 5, 0);
    check_end("fresh", 1'b0, 5);

    // full depth: words 0..1023, checksum = 1023*1024/2
    run_load(1024, 1, 32'h0007FE00);
    check_writes("full", 1024, 1);
    check_end("full", 1'b0, 1024);
    check("full_rdy_wr", 32'(ready_in_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
